demux12_buf: RTL

//   Buffered 1:2 demultiplexer, the inverse of the 2:1 mux. One input stream

---
 rtl/demux12_buf.sv | 83 ++++++++
 1 files changed

// File: rtl/demux12_buf.sv
// Buffered 1:2 demultiplexer. Each accepted word is routed by its select bit
// into a per-channel FIFO that has its own valid/ready output handshake.
`timescale 1ns/1ps
module demux12_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         s,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             f0_data,
  output logic                         f0_valid,
  input  logic                         f0_ready,
  output logic [WIDTH-1:0]             f1_data,
  output logic                         f1_valid,
  input  logic                         f1_ready,
  output logic [$clog2(DEPTH+1)-1:0]   cnt0,
  output logic [$clog2(DEPTH+1)-1:0]   cnt1
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem0 [DEPTH];
  logic [WIDTH-1:0] r_mem1 [DEPTH];
  logic [AW-1:0]    r_wp0, r_rp0, r_wp1, r_rp1;
  logic [CW-1:0]    r_cnt0, r_cnt1;

  logic w_push0, w_push1, w_pop0, w_pop1;

  // Full is judged on the current count only, so a same-cycle pop never
  // opens a slot for the word being offered.
  assign in_ready = s ? (r_cnt1 != FULL) : (r_cnt0 != FULL);
  assign w_push0  = in_valid && in_ready && !s;
  assign w_push1  = in_valid && in_ready &&  s;

  assign f0_valid = (r_cnt0 != '0);
  assign f1_valid = (r_cnt1 != '0);
  assign w_pop0   = f0_valid && f0_ready;
  assign w_pop1   = f1_valid && f1_ready;

  assign f0_data  = f0_valid ? r_mem0[r_rp0] : '0;
  assign f1_data  = f1_valid ? r_mem1[r_rp1] : '0;
  assign cnt0     = r_cnt0;
  assign cnt1     = r_cnt1;

  // Storage is deliberately left out of reset; the empty-state mux hides it.
  always_ff @(posedge clk) begin
    if (w_push0) r_mem0[r_wp0] <= in_data;
    if (w_push1) r_mem1[r_wp1] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp0  <= '0;
      r_rp0  <= '0;
      r_cnt0 <= '0;
      r_wp1  <= '0;
      r_rp1  <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_push0) r_wp0 <= r_wp0 + AW'(1);
      if (w_pop0)  r_rp0 <= r_rp0 + AW'(1);
      if (w_push1) r_wp1 <= r_wp1 + AW'(1);
      if (w_pop1)  r_rp1 <= r_rp1 + AW'(1);
      case ({w_push0, w_pop0})
        2'b10:   r_cnt0 <= r_cnt0 + CW'(1);
        2'b01:   r_cnt0 <= r_cnt0 - CW'(1);
        default: r_cnt0 <= r_cnt0;
      endcase
      case ({w_push1, w_pop1})
        2'b10:   r_cnt1 <= r_cnt1 + CW'(1);
        2'b01:   r_cnt1 <= r_cnt1 - CW'(1);
        default: r_cnt1 <= r_cnt1;
      endcase
    end
  end

endmodule
